// File: rtl/alu_op_sequencer.sv
// Command/response sequencer driving an external combinational ALU, with a find-first-set-and-clear macro.
// Optional `define ALU_SEQ_PIPELINE_EN lets a new command be accepted in the cycle a response is consumed.
module alu_op_sequencer #(
    parameter int BITWIDTH = 16,
    parameter int TAGWIDTH = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic [3:0]                      cmd_opcode,
    input  logic                            cmd_macro,
    input  logic [BITWIDTH-1:0]             cmd_a,
    input  logic [BITWIDTH-1:0]             cmd_b,
    input  logic [TAGWIDTH-1:0]             cmd_tag,
    output logic [BITWIDTH-1:0]             alu_a,
    output logic [BITWIDTH-1:0]             alu_b,
    output logic [3:0]                      alu_opcode,
    output logic                            alu_enable,
    input  logic [BITWIDTH-1:0]             alu_result,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [BITWIDTH-1:0]             rsp_data,
    output logic [$clog2(BITWIDTH):0]       rsp_index,
    output logic [TAGWIDTH-1:0]             rsp_tag
);

    localparam int IW = $clog2(BITWIDTH) + 1;

    localparam logic [3:0] OPC_BSF  = 4'hD;
    localparam logic [3:0] OPC_BCLR = 4'h1;

    typedef enum logic [1:0] {IDLE, OP1, OP2, RESP} state_t;

    state_t                r_state;
    state_t                w_next;
    logic [BITWIDTH-1:0]   r_a;
    logic [BITWIDTH-1:0]   r_b;
    logic [3:0]            r_op;
    logic                  r_macro;
    logic [TAGWIDTH-1:0]   r_tag;
    logic [IW-1:0]         r_idx;
    logic [BITWIDTH-1:0]   r_rsp_data;
    logic [IW-1:0]         r_rsp_index;
    logic                  w_accept;

    assign w_accept  = cmd_valid & cmd_ready;
    assign rsp_data  = r_rsp_data;
    assign rsp_index = r_rsp_index;
    assign rsp_tag   = r_tag;

    always_comb begin
        w_next     = r_state;
        cmd_ready  = 1'b0;
        rsp_valid  = 1'b0;
        alu_enable = 1'b0;
        alu_a      = '0;
        alu_b      = '0;
        alu_opcode = '0;
        case (r_state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) w_next = OP1;
            end
            OP1: begin
                alu_enable = 1'b1;
                alu_a      = r_a;
                alu_b      = r_b;
                alu_opcode = r_macro ? OPC_BSF : r_op;
                w_next     = r_macro ? OP2 : RESP;
            end
            OP2: begin
                alu_enable = 1'b1;
                alu_a      = r_a;
                alu_b      = {{(BITWIDTH-IW){1'b0}}, r_idx};
                alu_opcode = OPC_BCLR;
                w_next     = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
`ifdef ALU_SEQ_PIPELINE_EN
                cmd_ready = rsp_ready;
                if (rsp_ready) w_next = cmd_valid ? OP1 : IDLE;
`else
                if (rsp_ready) w_next = IDLE;
`endif
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= '0;
            r_macro     <= 1'b0;
            r_tag       <= '0;
            r_idx       <= '0;
            r_rsp_data  <= '0;
            r_rsp_index <= '0;
        end else begin
            r_state <= w_next;
            // Command capture is keyed on the handshake so RESP can also accept when pipelined.
            if (w_accept) begin
                r_a     <= cmd_a;
                r_b     <= cmd_b;
                r_op    <= cmd_opcode;
                r_macro <= cmd_macro;
                r_tag   <= cmd_tag;
            end
            case (r_state)
                OP1: begin
                    if (r_macro) begin
                        r_idx <= alu_result[IW-1:0];
                    end else begin
                        r_rsp_data  <= alu_result;
                        r_rsp_index <= '0;
                    end
                end
                OP2: begin
                    r_rsp_data  <= alu_result;
                    r_rsp_index <= r_idx;
                end
                default: ;
            endcase
        end
    end

endmodule
